// File: rtl/ghost_scheduler_if.sv
// Scheduler <-> game top-level bundle: Yoshi/ghost positions in, round control out.
interface ghost_scheduler_if #(
  parameter int unsigned N_GHOSTS = 4
);
  logic                    start;
  logic [9:0]              y_x;
  logic [9:0]              y_y;
  logic [10*N_GHOSTS-1:0]  g_x_bus;
  logic [10*N_GHOSTS-1:0]  g_y_bus;
  logic [N_GHOSTS-1:0]     ghost_en;
  logic                    ghost_reset;
  logic                    ghost_freeze;
  logic [25:0]             speed_offset;
  logic [3:0]              level;
  logic [1:0]              lives;
  logic                    game_over;
  logic                    hit;

  // Game top level: supplies positions and start, consumes round control.
  modport master (
    output start, y_x, y_y, g_x_bus, g_y_bus,
    input  ghost_en, ghost_reset, ghost_freeze, speed_offset, level, lives, game_over, hit
  );

  // Scheduler side.
  modport slave (
    input  start, y_x, y_y, g_x_bus, g_y_bus,
    output ghost_en, ghost_reset, ghost_freeze, speed_offset, level, lives, game_over, hit
  );
endinterface

// File: rtl/ghost_scheduler.sv
// Round controller for the chasing ghosts: staggered spawn, per-level speed ramp,
// Yoshi/ghost collision, lives and game-over.
// Optional build macro GHOST_SCHED_PAUSE_EN adds a 'pause' input whose rising edge
// toggles a paused flag while running.
module ghost_scheduler #(
  parameter int unsigned N_GHOSTS    = 4,
  parameter int unsigned LIVES_INIT  = 3,
  parameter int unsigned SPAWN_TICKS = 50000000,
  parameter int unsigned LEVEL_TICKS = 250000000,
  parameter int unsigned SPEED_STEP  = 250000,
  parameter int unsigned SPEED_MAX   = 3000000,
  parameter int unsigned HIT_HOLD    = 25000000,
  parameter int unsigned T_W         = 16
) (
  input logic clk,
  input logic reset,
`ifdef GHOST_SCHED_PAUSE_EN
  input logic pause,
`endif
  ghost_scheduler_if.slave bus
);

  localparam int unsigned SpawnW = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
  localparam int unsigned LevelW = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;
  localparam int unsigned HoldW  = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;
  localparam logic [N_GHOSTS-1:0] EnFirst = N_GHOSTS'(1);
  localparam logic [10:0] Tw = 11'(T_W);

  typedef enum logic [1:0] {StIdle, StRun, StHit, StOver} state_e;

  state_e              state_q, state_d;
  logic [N_GHOSTS-1:0] ghost_en_q, ghost_en_d;
  logic                ghost_reset_q, ghost_reset_d;
  logic                freeze_q, freeze_d;
  logic [25:0]         speed_q, speed_d;
  logic [3:0]          level_q, level_d;
  logic [1:0]          lives_q, lives_d;
  logic                game_over_q, game_over_d;
  logic                hit_q, hit_d;
  logic [SpawnW-1:0]   spawn_cnt_q, spawn_cnt_d;
  logic [LevelW-1:0]   lvl_cnt_q, lvl_cnt_d;
  logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
  logic                coll_q, coll_d;
  logic                overlap;
  logic [31:0]         speed_sum;
  logic                run_paused;

`ifdef GHOST_SCHED_PAUSE_EN
  logic paused_q, paused_d, pause_prev_q, pause_edge;
  assign pause_edge = pause & ~pause_prev_q;
  assign run_paused = paused_q;

  // Pause edge detector and paused flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pause_prev_q <= 1'b0;
      paused_q     <= 1'b0;
    end else begin
      pause_prev_q <= pause;
      paused_q     <= paused_d;
    end
  end
`else
  assign run_paused = 1'b0;
`endif

  // 32-bit sum so the saturation test cannot be fooled by a 26-bit wrap.
  assign speed_sum = 32'(speed_q) + SPEED_STEP;

  // Bounding-box overlap of Yoshi with any enabled ghost, 11-bit to avoid edge overflow.
  always_comb begin
    overlap = 1'b0;
    for (int i = 0; i < int'(N_GHOSTS); i++) begin
      logic [10:0] gx, gy, yx, yy;
      gx = {1'b0, bus.g_x_bus[10*i +: 10]};
      gy = {1'b0, bus.g_y_bus[10*i +: 10]};
      yx = {1'b0, bus.y_x};
      yy = {1'b0, bus.y_y};
      if (ghost_en_q[i] && (gx < yx + Tw) && (yx < gx + Tw) &&
          (gy < yy + Tw) && (yy < gy + Tw)) begin
        overlap = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic for the round FSM.
  always_comb begin
    state_d       = state_q;
    ghost_en_d    = ghost_en_q;
    ghost_reset_d = 1'b0;
    freeze_d      = freeze_q;
    speed_d       = speed_q;
    level_d       = level_q;
    lives_d       = lives_q;
    game_over_d   = game_over_q;
    hit_d         = 1'b0;
    spawn_cnt_d   = spawn_cnt_q;
    lvl_cnt_d     = lvl_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    coll_d        = 1'b0;
`ifdef GHOST_SCHED_PAUSE_EN
    paused_d      = 1'b0;
`endif

    unique case (state_q)
      StIdle, StOver: begin
        if (bus.start) begin
          state_d       = StRun;
          ghost_reset_d = 1'b1;
          ghost_en_d    = EnFirst;
          freeze_d      = 1'b0;
          speed_d       = '0;
          level_d       = '0;
          lives_d       = 2'(LIVES_INIT);
          game_over_d   = 1'b0;
          spawn_cnt_d   = '0;
          lvl_cnt_d     = '0;
          hold_cnt_d    = '0;
        end
      end

      StRun: begin
`ifdef GHOST_SCHED_PAUSE_EN
        paused_d = paused_q ^ pause_edge;
        freeze_d = paused_d;
`endif
        if (!run_paused) begin
          // The first cycle after a ghost_reset pulse still sees stale ghost positions.
          coll_d = overlap & ~ghost_reset_q;

          if (!(&ghost_en_q)) begin
            if (spawn_cnt_q == SpawnW'(SPAWN_TICKS - 1)) begin
              spawn_cnt_d = '0;
              ghost_en_d  = (ghost_en_q << 1) | EnFirst;
            end else begin
              spawn_cnt_d = spawn_cnt_q + SpawnW'(1);
            end
          end

          if (lvl_cnt_q == LevelW'(LEVEL_TICKS - 1)) begin
            lvl_cnt_d = '0;
            if (level_q != 4'd15) level_d = level_q + 4'd1;
            speed_d = (speed_sum >= SPEED_MAX) ? 26'(SPEED_MAX) : speed_sum[25:0];
          end else begin
            lvl_cnt_d = lvl_cnt_q + LevelW'(1);
          end

          // Counter updates above still land in the same cycle as the hit.
          if (coll_q) begin
            state_d    = StHit;
            hit_d      = 1'b1;
            freeze_d   = 1'b1;
            hold_cnt_d = '0;
            if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
`ifdef GHOST_SCHED_PAUSE_EN
            paused_d   = 1'b0;
`endif
          end
        end
      end

      StHit: begin
        if (hold_cnt_q == HoldW'(HIT_HOLD - 1)) begin
          hold_cnt_d = '0;
          if (lives_q == 2'd0) begin
            state_d     = StOver;
            game_over_d = 1'b1;
          end else begin
            state_d       = StRun;
            ghost_reset_d = 1'b1;
            freeze_d      = 1'b0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      ghost_en_q    <= '0;
      ghost_reset_q <= 1'b1;
      freeze_q      <= 1'b1;
      speed_q       <= '0;
      level_q       <= '0;
      lives_q       <= 2'(LIVES_INIT);
      game_over_q   <= 1'b0;
      hit_q         <= 1'b0;
      spawn_cnt_q   <= '0;
      lvl_cnt_q     <= '0;
      hold_cnt_q    <= '0;
      coll_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ghost_en_q    <= ghost_en_d;
      ghost_reset_q <= ghost_reset_d;
      freeze_q      <= freeze_d;
      speed_q       <= speed_d;
      level_q       <= level_d;
      lives_q       <= lives_d;
      game_over_q   <= game_over_d;
      hit_q         <= hit_d;
      spawn_cnt_q   <= spawn_cnt_d;
      lvl_cnt_q     <= lvl_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      coll_q        <= coll_d;
    end
  end

  assign bus.ghost_en     = ghost_en_q;
  assign bus.ghost_reset  = ghost_reset_q;
  assign bus.ghost_freeze = freeze_q;
  assign bus.speed_offset = speed_q;
  assign bus.level        = level_q;
  assign bus.lives        = lives_q;
  assign bus.game_over    = game_over_q;
  assign bus.hit          = hit_q;

endmodule

// File: tb/tb_ghost_scheduler.sv
// Self-checking bench for ghost_scheduler: directed round sequences, a collision
// geometry table and a randomized run against an elapsed-time reference model.
module tb_ghost_scheduler;
  localparam int N      = 4;
  localparam int SPAWN  = 10;
  localparam int LEVEL  = 20;
  localparam int STEP   = 100;
  localparam int SMAX   = 250;
  localparam int HOLD   = 5;
  localparam int TW     = 16;
  localparam int LIVES0 = 3;

  localparam int MIdle = 0, MRun = 1, MHit = 2, MOver = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef GHOST_SCHED_PAUSE_EN
  logic pause = 1'b0;
`endif

  always #5 clk = ~clk;

  ghost_scheduler_if #(.N_GHOSTS(N)) bif ();

  ghost_scheduler #(
    .N_GHOSTS(N), .LIVES_INIT(LIVES0), .SPAWN_TICKS(SPAWN), .LEVEL_TICKS(LEVEL),
    .SPEED_STEP(STEP), .SPEED_MAX(SMAX), .HIT_HOLD(HOLD), .T_W(TW)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef GHOST_SCHED_PAUSE_EN
    .pause(pause),
`endif
    .bus(bif)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: round mode plus number of running cycles since start.
  int m_mode, m_run, m_hold, m_lives;
  bit m_pend, m_greset, m_hit;

  typedef struct {
    int gx; int gy; int yx; int yy; bit hit;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ghost(input int i, input int x, input int y);
    bif.g_x_bus[10*i +: 10] = 10'(x);
    bif.g_y_bus[10*i +: 10] = 10'(y);
  endtask

  task automatic set_yoshi(input int x, input int y);
    bif.y_x = 10'(x);
    bif.y_y = 10'(y);
  endtask

  function automatic int clamp10(input int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  task automatic m_reset();
    m_mode = MIdle; m_run = 0; m_hold = 0; m_lives = LIVES0;
    m_pend = 0; m_greset = 1; m_hit = 0;
  endtask

  function automatic int m_nbits();
    int nb;
    if (m_mode == MIdle) return 0;
    nb = 1 + m_run / SPAWN;
    return (nb > N) ? N : nb;
  endfunction

  function automatic bit m_overlap();
    int nb, gx, gy, yx, yy;
    nb = m_nbits();
    yx = int'(bif.y_x);
    yy = int'(bif.y_y);
    for (int i = 0; i < nb; i++) begin
      gx = int'(bif.g_x_bus[10*i +: 10]);
      gy = int'(bif.g_y_bus[10*i +: 10]);
      if (gx < yx + TW && yx < gx + TW && gy < yy + TW && yy < gy + TW) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [39:0] m_expect();
    int lw, lv, sp;
    logic [3:0] en;
    lw = m_run / LEVEL;
    lv = (lw > 15) ? 15 : lw;
    sp = lw * STEP;
    if (sp > SMAX) sp = SMAX;
    en = 4'((1 << m_nbits()) - 1);
    return {en, m_greset, (m_mode != MRun), 26'(sp), 4'(lv), 2'(m_lives),
            (m_mode == MOver), m_hit};
  endfunction

  task automatic m_step();
    bit ov, was_pend;
    ov = m_overlap();
    case (m_mode)
      MIdle, MOver: begin
        m_hit = 0; m_pend = 0;
        if (bif.start) begin
          m_mode = MRun; m_run = 0; m_lives = LIVES0; m_greset = 1;
        end else begin
          m_greset = 0;
        end
      end
      MRun: begin
        was_pend = m_pend;
        m_pend = ov && !m_greset;
        m_greset = 0; m_hit = 0;
        m_run++;
        if (was_pend) begin
          m_mode = MHit; m_lives--; m_hit = 1; m_hold = 0;
        end
      end
      default: begin
        m_hit = 0; m_pend = 0; m_greset = 0;
        if (m_hold == HOLD - 1) begin
          if (m_lives == 0) m_mode = MOver;
          else begin m_mode = MRun; m_greset = 1; end
        end else begin
          m_hold++;
        end
      end
    endcase
  endtask

  function automatic logic [39:0] dut_vec();
    return {bif.ghost_en, bif.ghost_reset, bif.ghost_freeze, bif.speed_offset, bif.level,
            bif.lives, bif.game_over, bif.hit};
  endfunction

  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bif.start = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_hit(output bit seen);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (bif.hit) seen = 1;
    end
  endtask

  task automatic start_round();
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int n, extra;
    logic [3:0] en_held;
    logic [25:0] sp_held;

    vecs[0]  = '{100, 100, 115, 115, 1'b1};
    vecs[1]  = '{100, 100, 116, 100, 1'b0};
    vecs[2]  = '{100, 100, 84, 100, 1'b0};
    vecs[3]  = '{100, 100, 85, 100, 1'b1};
    vecs[4]  = '{100, 100, 100, 116, 1'b0};
    vecs[5]  = '{100, 100, 100, 85, 1'b1};
    vecs[6]  = '{1010, 1010, 1000, 1000, 1'b1};
    vecs[7]  = '{1023, 1023, 1008, 1008, 1'b1};
    vecs[8]  = '{1023, 0, 1007, 0, 1'b0};
    vecs[9]  = '{0, 0, 1020, 0, 1'b0};
    vecs[10] = '{0, 0, 15, 15, 1'b1};

    bif.start = 1'b0;
    set_yoshi(300, 300);
    for (int i = 0; i < N; i++) set_ghost(i, 17, 17);

    // Asynchronous reset without any clock edge.
    #2 reset = 1'b0;
    m_reset();
    #1;
    chk("rst_ghost_reset", bif.ghost_reset, 1);
    chk("rst_freeze", bif.ghost_freeze, 1);
    chk("rst_lives", bif.lives, 3);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Idle for 50 cycles.
    repeat (50) tick();
    chk("idle_en", bif.ghost_en, 0);
    chk("idle_freeze", bif.ghost_freeze, 1);
    chk("idle_lives", bif.lives, 3);
    chk("idle_speed", bif.speed_offset, 0);
    chk("idle_level", bif.level, 0);
    chk("idle_over", bif.game_over, 0);

    // Spawn stagger and speed ramp.
    start_round();
    chk("start_en", bif.ghost_en, 4'b0001);
    chk("start_greset", bif.ghost_reset, 1);
    chk("start_freeze", bif.ghost_freeze, 0);
    for (int k = 1; k <= 80; k++) begin
      tick();
      case (k)
        1:  chk("greset_one_cycle", bif.ghost_reset, 0);
        9:  chk("en_k9", bif.ghost_en, 4'b0001);
        10: chk("en_k10", bif.ghost_en, 4'b0011);
        19: chk("speed_k19", bif.speed_offset, 0);
        20: chk("speed_k20", bif.speed_offset, 100);
        29: chk("en_k29", bif.ghost_en, 4'b0111);
        30: chk("en_k30", bif.ghost_en, 4'b1111);
        40: chk("speed_k40", bif.speed_offset, 200);
        60: chk("speed_k60", bif.speed_offset, 250);
        80: begin
          chk("speed_k80", bif.speed_offset, 250);
          chk("level_k80", bif.level, 4);
        end
        default: ;
      endcase
    end

    // First hit: pulse, lives, freeze length, ghost_reset on return.
    set_ghost(0, 100, 100);
    set_yoshi(115, 115);
    wait_hit(seen);
    set_yoshi(300, 300);
    chk("hit1_seen", seen, 1);
    chk("hit1_lives", bif.lives, 2);
    chk("hit1_freeze", bif.ghost_freeze, 1);
    n = 1; extra = 0;
    while (bif.ghost_freeze && n < 20) begin
      tick();
      if (bif.hit) extra++;
      if (bif.ghost_freeze) n++;
    end
    chk("hit1_hold_len", n, HOLD);
    chk("hit1_pulse_width", extra, 0);
    chk("hit1_return_greset", bif.ghost_reset, 1);
    chk("hit1_en_kept", bif.ghost_en, 4'b1111);
    tick();
    chk("hit1_greset_done", bif.ghost_reset, 0);

    // Two more hits end the game.
    for (int h = 1; h <= 2; h++) begin
      set_yoshi(115, 115);
      wait_hit(seen);
      set_yoshi(300, 300);
      chk($sformatf("hit%0d_seen", h + 1), seen, 1);
      chk($sformatf("hit%0d_lives", h + 1), bif.lives, 2 - h);
      if (h == 1) repeat (HOLD + 1) tick();
    end
    repeat (HOLD - 1) tick();
    chk("over_not_yet", bif.game_over, 0);
    tick();
    chk("over_flag", bif.game_over, 1);
    chk("over_lives", bif.lives, 0);
    chk("over_freeze", bif.ghost_freeze, 1);
    repeat (5) tick();
    chk("over_en_kept", bif.ghost_en, 4'b1111);
    chk("over_held", bif.game_over, 1);

    // Restart from OVER.
    start_round();
    chk("restart_lives", bif.lives, 3);
    chk("restart_level", bif.level, 0);
    chk("restart_en", bif.ghost_en, 4'b0001);
    chk("restart_over", bif.game_over, 0);
    chk("restart_speed", bif.speed_offset, 0);

    // Two ghosts overlapping Yoshi in the same cycle count once.
    repeat (12) tick();
    set_ghost(1, 100, 100);
    set_yoshi(110, 110);
    wait_hit(seen);
    set_yoshi(300, 300);
    chk("dual_seen", seen, 1);
    chk("dual_lives", bif.lives, 2);
    extra = 0;
    repeat (10) begin
      tick();
      if (bif.hit) extra++;
    end
    chk("dual_no_second_hit", extra, 0);
    chk("dual_lives_after", bif.lives, 2);
    set_ghost(1, 17, 17);

    // Collision geometry table, single ghost enabled.
    foreach (vecs[v]) begin
      set_yoshi(300, 300);
      set_ghost(0, 700, 700);
      for (int i = 1; i < N; i++) set_ghost(i, 500, 20);
      do_reset();
      start_round();
      tick();
      set_ghost(0, vecs[v].gx, vecs[v].gy);
      set_yoshi(vecs[v].yx, vecs[v].yy);
      seen = 0;
      repeat (4) begin
        tick();
        if (bif.hit) seen = 1;
      end
      chk($sformatf("geom%0d_hit", v), seen, vecs[v].hit);
      chk($sformatf("geom%0d_lives", v), bif.lives, vecs[v].hit ? 2 : 3);
    end

    // Reset asserted while frozen in HIT.
    set_yoshi(300, 300);
    set_ghost(0, 100, 100);
    do_reset();
    start_round();
    tick();
    set_yoshi(115, 115);
    wait_hit(seen);
    set_yoshi(300, 300);
    chk("rsthit_seen", seen, 1);
    tick();
    tick();
    #1 reset = 1'b0;
    m_reset();
    #1;
    chk("rsthit_outputs", dut_vec(), {4'b0000, 1'b1, 1'b1, 26'd0, 4'd0, 2'd3, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Randomized run against the reference model.
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      int r, k;
      if (c % 40 == 0)
        for (int i = 0; i < N; i++)
          set_ghost(i, $urandom_range(0, 1023), $urandom_range(0, 1023));
      r = $urandom_range(0, 7);
      if (r == 0) begin
        k = $urandom_range(0, N - 1);
        set_yoshi(clamp10(int'(bif.g_x_bus[10*k +: 10]) + $urandom_range(0, 36) - 18),
                  clamp10(int'(bif.g_y_bus[10*k +: 10]) + $urandom_range(0, 36) - 18));
      end else if (r == 1) begin
        set_yoshi($urandom_range(0, 1023), $urandom_range(0, 1023));
      end
      bif.start = ($urandom_range(0, 31) == 0);
      tick();
      chk($sformatf("rand_c%0d", c), dut_vec(), m_expect());
    end
    bif.start = 1'b0;

`ifdef GHOST_SCHED_PAUSE_EN
    // Pause freezes counters and masks collisions; second edge resumes.
    set_yoshi(300, 300);
    for (int i = 0; i < N; i++) set_ghost(i, 500, 20);
    set_ghost(0, 100, 100);
    do_reset();
    start_round();
    repeat (5) tick();
    pause = 1'b1;
    tick();
    pause = 1'b0;
    chk("pause_freeze", bif.ghost_freeze, 1);
    en_held = bif.ghost_en;
    sp_held = bif.speed_offset;
    set_yoshi(115, 115);
    extra = 0;
    repeat (30) begin
      tick();
      if (bif.hit) extra++;
    end
    chk("pause_no_hit", extra, 0);
    chk("pause_en_held", bif.ghost_en, en_held);
    chk("pause_speed_held", bif.speed_offset, sp_held);
    set_yoshi(300, 300);
    pause = 1'b1;
    tick();
    pause = 1'b0;
    chk("resume_freeze", bif.ghost_freeze, 0);
    repeat (12) tick();
    chk("resume_en_grows", (bif.ghost_en != en_held), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
